// File: rtl/sar_search.sv
// Successive-approximation search engine. Drives a trial value onto the
// magnitude comparator's B operand and resolves the unknown A operand one
// bit per cycle, MSB first, with an early exit on equality.
//
// state | meaning
// IDLE  | waiting for start, trial parked at 0
// TRY   | one compare per cycle, refining trial bit k
// DONE  | one-cycle result pulse, trial held
module sar_search #(
   parameter int N  = 8,
   parameter int SW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          cmp_gr,
   input  logic          cmp_le,
   input  logic          cmp_eq,
   output logic [N-1:0]  trial,
   output logic          busy,
   output logic          done,
   output logic [N-1:0]  result,
   output logic [SW-1:0] steps,
   output logic          err
);

   localparam int KW = $clog2(N);

   typedef enum logic [1:0] {IDLE, TRY, DONE} state_t;

   state_t        state;
   logic [KW-1:0] k;
   logic [SW-1:0] cnt;
   logic [SW-1:0] cnt_nxt;
   logic          flags_ok;
   logic [N-1:0]  bit_k;
   logic [N-1:0]  bit_km1;

   // Flag validity and the bit masks for the bit currently being resolved.
   always_comb begin
      flags_ok = (cmp_gr ^ cmp_le ^ cmp_eq) & ~(cmp_gr & cmp_le & cmp_eq);
      bit_k    = {{(N-1){1'b0}}, 1'b1} << k;
      bit_km1  = bit_k >> 1;
      cnt_nxt  = cnt + 1'b1;
   end

   // Search sequencer; all outputs are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         trial  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         steps  <= '0;
         err    <= 1'b0;
         k      <= '0;
         cnt    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               trial <= '0;
               busy  <= 1'b0;
               if (start) begin
                  trial <= {1'b1, {(N-1){1'b0}}};
                  k     <= KW'(N-1);
                  cnt   <= '0;
                  err   <= 1'b0;
                  busy  <= 1'b1;
                  state <= TRY;
               end
            end
            TRY: begin
               cnt <= cnt_nxt;
               // Any exit from TRY publishes the final compare count with done.
               if (!flags_ok || cmp_eq || k == '0) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  steps  <= cnt_nxt;
                  result <= trial;
                  if (!flags_ok) begin
                     err <= 1'b1;
                  end else if (!cmp_eq) begin
                     // Last bit: "less" clears bit0, "greater" cannot happen.
                     if (cmp_le)
                        result <= trial & {{(N-1){1'b1}}, 1'b0};
                     else
                        err <= 1'b1;
                  end
               end else begin
                  if (cmp_gr)
                     trial <= trial | bit_km1;
                  else
                     trial <= (trial & ~bit_k) | bit_km1;
                  k <= k - 1'b1;
               end
            end
            DONE: begin
               trial <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
